// File: rtl/alu_datapath_pipe.sv
// Two-stage issue/execute ALU datapath: register file, flag register, operand/flag
// bypass from EX, and an iterative shift-add multiplier that stalls issue.
module alu_datapath_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int MUL_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [3:0]        op,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] ra,
    input  logic [REG_AW-1:0] rb,
    input  logic              imm_sel,
    input  logic [DATA_W-1:0] imm,
    input  logic              wb_en,
    input  logic              flag_en,
    output logic              result_valid,
    output logic [DATA_W-1:0] result,
    output logic [REG_AW-1:0] result_rd,
    output logic [3:0]        flags,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    // state   | meaning
    // IDLE    | no multiply in flight; EX holds a single-cycle op or a bubble
    // MUL     | shift-add iterations running, issue stalled
    // DONE    | product final in EX; retires at next edge, issue open again
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_CMP  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_MOV  = 4'd8;
    localparam logic [3:0] OP_LSH  = 4'd9;
    localparam logic [3:0] OP_RSH  = 4'd10;
    localparam logic [3:0] OP_ARSH = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    localparam int NUM_REGS = 2 ** REG_AW;
    localparam int SH_W     = $clog2(DATA_W);
    localparam int CNT_W    = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [3:0]        flags_q;

    logic              ex_valid;
    logic [3:0]        ex_op;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic              ex_wb;
    logic              ex_fe;
    logic              ex_cin;

    logic [1:0]        state;
    logic [DATA_W-1:0] mul_acc;
    logic [DATA_W-1:0] mul_mcand;
    logic [DATA_W-1:0] mul_mplier;
    logic [CNT_W-1:0]  mul_cnt;

    logic              ex_is_mul;
    logic              ex_retire;
    logic              accept;
    logic              new_is_mul;
    logic              new_nop;
    logic              new_wb;
    logic              new_fe;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              cin;

    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_flags;
    logic [DATA_W:0]   add_ext;
    logic [DATA_W:0]   sub_ext;
    logic [DATA_W:0]   shl_ext;
    logic [DATA_W:0]   shr_ext;
    logic [DATA_W:0]   sar_ext;
    logic [SH_W-1:0]   sh;
    logic              alu_c;
    logic              alu_v;

    assign ex_is_mul   = (MUL_EN != 0) && (ex_op == OP_MUL);
    assign ex_retire   = ex_valid && (!ex_is_mul || (state == ST_DONE));
    assign issue_ready = (state != ST_MUL);
    assign accept      = issue_valid && issue_ready;

    // Opcodes 13-15 and a disabled MUL never write registers or flags.
    assign new_is_mul = (MUL_EN != 0) && (op == OP_MUL);
    assign new_nop    = (op >= 4'd13) || ((MUL_EN == 0) && (op == OP_MUL));
    assign new_wb     = wb_en && !new_nop && (op != OP_CMP);
    assign new_fe     = flag_en && !new_nop;

    // EX is always retiring when a new instruction is accepted, so its ALU output is current.
    always_comb begin
        opa = regs[ra];
        opb = regs[rb];
        if (ex_retire && ex_wb && (ex_rd == ra)) opa = alu_res;
        if (ex_retire && ex_wb && (ex_rd == rb)) opb = alu_res;
        if (imm_sel) opb = imm;
        cin = (ex_retire && ex_fe) ? alu_flags[0] : flags_q[0];
    end

    always_comb begin
        sh      = ex_b[SH_W-1:0];
        add_ext = {1'b0, ex_a} + {1'b0, ex_b} + {{DATA_W{1'b0}}, (ex_op == OP_ADDC) && ex_cin};
        sub_ext = {1'b0, ex_a} + {1'b0, ~ex_b} + {{DATA_W{1'b0}}, 1'b1};
        shl_ext = {1'b0, ex_a} << sh;
        shr_ext = {ex_a, 1'b0} >> sh;
        sar_ext = $signed({ex_a, 1'b0}) >>> sh;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (ex_op)
            OP_ADD, OP_ADDC: begin
                alu_res = add_ext[DATA_W-1:0];
                alu_c   = add_ext[DATA_W];
                alu_v   = (ex_a[DATA_W-1] == ex_b[DATA_W-1]) && (add_ext[DATA_W-1] != ex_a[DATA_W-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = sub_ext[DATA_W-1:0];
                alu_c   = ~sub_ext[DATA_W];
                alu_v   = (ex_a[DATA_W-1] != ex_b[DATA_W-1]) && (sub_ext[DATA_W-1] != ex_a[DATA_W-1]);
            end
            OP_AND:  alu_res = ex_a & ex_b;
            OP_OR:   alu_res = ex_a | ex_b;
            OP_XOR:  alu_res = ex_a ^ ex_b;
            OP_NOT:  alu_res = ~ex_a;
            OP_MOV:  alu_res = ex_b;
            OP_LSH: begin
                alu_res = shl_ext[DATA_W-1:0];
                alu_c   = shl_ext[DATA_W];
            end
            OP_RSH: begin
                alu_res = shr_ext[DATA_W:1];
                alu_c   = shr_ext[0];
            end
            OP_ARSH: begin
                alu_res = sar_ext[DATA_W:1];
                alu_c   = sar_ext[0];
            end
            OP_MUL: begin
                if (MUL_EN != 0) alu_res = mul_acc;
            end
            default: alu_res = '0;
        endcase
        alu_flags = {alu_v, alu_res[DATA_W-1], (alu_res == '0), alu_c};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid <= 1'b0;
            ex_op    <= '0;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_wb    <= 1'b0;
            ex_fe    <= 1'b0;
            ex_cin   <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
            ex_op    <= op;
            ex_rd    <= rd;
            ex_a     <= opa;
            ex_b     <= opb;
            ex_wb    <= new_wb;
            ex_fe    <= new_fe;
            ex_cin   <= cin;
        end else if (ex_retire) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            flags_q      <= '0;
            result_valid <= 1'b0;
            result       <= '0;
            result_rd    <= '0;
        end else begin
            result_valid <= ex_retire;
            if (ex_retire) begin
                result    <= alu_res;
                result_rd <= ex_rd;
                if (ex_wb) regs[ex_rd] <= alu_res;
                if (ex_fe) flags_q <= alu_flags;
            end
        end
    end

    // Multiplier: accumulator holds its value through DONE so EX can read it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
        end else begin
            case (state)
                ST_MUL: begin
                    if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_cnt    <= mul_cnt - CNT_W'(1);
                    if (mul_cnt == CNT_W'(1)) state <= ST_DONE;
                end
                default: begin
                    if (accept && new_is_mul) begin
                        state      <= ST_MUL;
                        mul_acc    <= '0;
                        mul_mcand  <= opa;
                        mul_mplier <= opb;
                        mul_cnt    <= CNT_W'(DATA_W);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign flags    = flags_q;
    assign dbg_data = regs[dbg_addr];

endmodule
